lvds_rx_deframer: RTL and testbench
===================================

LVDS_RX_DEFRAMER -- requirements
Module: lvds_rx_deframer

Interface
REQ-001 The block SHALL have one clock and an active-low reset: the clock is rx_inclock and the reset is reset_n, which is asynchronous.
REQ-002 The block SHALL have these parameters (name, default, meaning):
- TRAIN_PAT, 8'h6A, training byte sent by the remote transmitter.
- MARK_PAT, 8'h77, start-of-data marker byte.
- SETTLE_CYC, 8, cycles to hold rx_data_align low after the training pattern matches.
- FIFO_DEPTH, 4, output buffer entries (power of two).
REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- rx_inclock  in  1  clock.
- reset_n  in  1  async active-low reset.
- rx_locked  in  1  receiver PLL lock.
- rx_out  in  8  parallel byte from the deserializer.
- rx_data_align  out  1  bitslip request to the deserializer.
- rx_align_done  out  1  alignment complete; returned to the remote transmitter.
- deq_rx  out  32  received word.
- EN_deq_rx  out  1  one-cycle strobe that enqueues deq_rx into the sink.
- RDY_deq_rx  in  1  sink can accept a word.
- led_rx_state  out  4  current state encoding.
- drop_cnt  out  8  overflow count; present only with LVDS_RX_DROP_CNT_EN.

Function
REQ-004 The FSM SHALL use these states, and led_rx_state SHALL equal the state encoding:
- IDLE=0, HUNT=1, SETTLE=2, MARK=3, B0=4, B1=5, B2=6, B3=7.
REQ-005 IDLE SHALL go to HUNT when rx_locked=1; otherwise it SHALL stay in IDLE with rx_data_align=1.
REQ-006 HUNT: if rx_out==TRAIN_PAT, the FSM SHALL set rx_data_align=0 and go to SETTLE; otherwise it SHALL invert rx_data_align every cycle.
REQ-007 SETTLE SHALL hold rx_data_align=0 for SETTLE_CYC cycles, then set rx_align_done=1 and go to MARK.
REQ-008 MARK SHALL stay in MARK until rx_out==MARK_PAT, then go to B0.
REQ-009 B0..B3 SHALL capture rx_out into word bits [31:24], [23:16], [15:8] and [7:0] respectively; B3 SHALL return to B0.
REQ-010 At B3, the assembled word SHALL be pushed to the FIFO only if bit31==1; words with bit31==0 are idle fill and SHALL be discarded.
REQ-011 A push SHALL succeed if FIFO count<FIFO_DEPTH or a pop occurs in the same cycle; otherwise the word SHALL be dropped.
REQ-012 Pop: when the FIFO is non-empty and RDY_deq_rx=1, the next edge SHALL register deq_rx=head, EN_deq_rx=1 and advance the head; EN_deq_rx SHALL be 0 in every other cycle.
REQ-013 Latency SHALL be 1 cycle from a successful push into an empty FIFO (with RDY_deq_rx=1) to EN_deq_rx high.
REQ-014 deq_rx SHALL hold its last value while EN_deq_rx=0.
REQ-015 FIFO pointers SHALL wrap modulo FIFO_DEPTH, and count SHALL stay within 0..FIFO_DEPTH.
REQ-016 rx_locked=0 in any state other than IDLE SHALL, on the next edge:
- go to IDLE;
- clear rx_align_done;
- discard the partially assembled word;
- retain the FIFO contents, which continue to drain.
REQ-017 rx_align_done SHALL be 1 only in MARK and B0..B3.

Reset
REQ-018 Asserting reset_n=0 SHALL immediately set:
- state=IDLE;
- rx_data_align=1, rx_align_done=0;
- EN_deq_rx=0, deq_rx=0;
- FIFO empty;
- settle counter=0, drop_cnt=0.
REQ-019 After reset_n releases, the FSM SHALL leave IDLE no earlier than the first rx_inclock edge that samples rx_locked=1.

Configuration
REQ-020 With LVDS_RX_DROP_CNT_EN defined, drop_cnt SHALL increment by one for every dropped word and SHALL saturate at 8'hFF.
REQ-021 Without LVDS_RX_DROP_CNT_EN, the drop_cnt port and its register SHALL be absent, and drops SHALL be silent; all other behaviour is identical.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Reset, rx_locked=1, rx_out=0x35 for 5 cycles then 0x6A -> rx_data_align toggles for 5 cycles, then 0; rx_align_done=1 after 8 cycles in SETTLE.
- After MARK, feed 0x77, then bytes 0x81,0x22,0x33,0x44 with RDY_deq_rx=1 -> one EN_deq_rx pulse with deq_rx=0x81223344 one cycle after B3.
- Feed word 0x12345678 (bit31=0) -> no EN_deq_rx pulse.
- RDY_deq_rx=0, send 6 valid words 0x80000001..0x80000006 -> FIFO holds words 1..4 and drop_cnt=2; then RDY_deq_rx=1 -> 4 pulses in order 1..4.
- Drop rx_locked mid-word during B2 -> state=IDLE and rx_align_done=0 next cycle; buffered words still drain; no partial word is emitted.
- Assert reset_n asynchronously mid-B1 -> all outputs take their REQ-018 values without waiting for a clock edge.

Source files
------------

// File: rtl/lvds_rx_deframer.sv
// lvds_rx_deframer: bitslip training, marker hunt, 32-bit word assembly and output FIFO.
// Define LVDS_RX_DROP_CNT_EN to add the saturating drop_cnt overflow counter.
module lvds_rx_deframer #(
    parameter logic [7:0] TRAIN_PAT  = 8'h6A,
    parameter logic [7:0] MARK_PAT   = 8'h77,
    parameter int         SETTLE_CYC = 8,
    parameter int         FIFO_DEPTH = 4
) (
    input  logic        rx_inclock,
    input  logic        reset_n,
    input  logic        rx_locked,
    input  logic [7:0]  rx_out,
    output logic        rx_data_align,
    output logic        rx_align_done,
    output logic [31:0] deq_rx,
    output logic        EN_deq_rx,
    input  logic        RDY_deq_rx,
    output logic [3:0]  led_rx_state
`ifdef LVDS_RX_DROP_CNT_EN
    ,
    output logic [7:0]  drop_cnt
`endif
);
    typedef enum logic [2:0] {IDLE, HUNT, SETTLE, MARK, B0, B1, B2, B3} state_t;
    localparam int AW = $clog2(FIFO_DEPTH);

    state_t        state_q;
    logic          align_q, done_q, en_q;
    logic [7:0]    settle_q;
    logic [23:0]   word_q;
    logic [31:0]   deq_q;
    logic [31:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] rd_q, wr_q;
    logic [AW:0]   cnt_q;
    logic [31:0]   word_full;
    logic          push_req, pop, push;

    assign word_full = {word_q, rx_out};
    assign push_req  = rx_locked && state_q == B3 && word_full[31];
    assign pop       = cnt_q != '0 && RDY_deq_rx;
    // count never exceeds the power-of-two depth, so its MSB alone means full
    assign push      = push_req && (!cnt_q[AW] || pop);

    always_ff @(posedge rx_inclock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            align_q  <= 1'b1;
            done_q   <= 1'b0;
            settle_q <= '0;
            word_q   <= '0;
        end else if (!rx_locked) begin
            state_q  <= IDLE;
            align_q  <= 1'b1;
            done_q   <= 1'b0;
            settle_q <= '0;
            word_q   <= '0;
        end else begin
            case (state_q)
                IDLE: state_q <= HUNT;
                HUNT: begin
                    if (rx_out == TRAIN_PAT) begin
                        align_q  <= 1'b0;
                        settle_q <= '0;
                        state_q  <= SETTLE;
                    end else begin
                        align_q <= ~align_q;
                    end
                end
                SETTLE: begin
                    if (settle_q == 8'(SETTLE_CYC - 1)) begin
                        done_q  <= 1'b1;
                        state_q <= MARK;
                    end else begin
                        settle_q <= settle_q + 8'd1;
                    end
                end
                MARK: state_q <= (rx_out == MARK_PAT) ? B0 : MARK;
                B0: begin
                    word_q[23:16] <= rx_out;
                    state_q       <= B1;
                end
                B1: begin
                    word_q[15:8] <= rx_out;
                    state_q      <= B2;
                end
                B2: begin
                    word_q[7:0] <= rx_out;
                    state_q     <= B3;
                end
                B3: state_q <= B0;
            endcase
        end
    end

    always_ff @(posedge rx_inclock or negedge reset_n) begin
        if (!reset_n) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
            en_q  <= 1'b0;
            deq_q <= '0;
        end else begin
            en_q  <= pop;
            cnt_q <= cnt_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
            if (pop) begin
                deq_q <= mem_q[rd_q];
                rd_q  <= rd_q + 1'b1;
            end
            if (push) wr_q <= wr_q + 1'b1;
        end
    end

    always_ff @(posedge rx_inclock) begin
        if (push) mem_q[wr_q] <= word_full;
    end

`ifdef LVDS_RX_DROP_CNT_EN
    logic [7:0] drop_q;

    always_ff @(posedge rx_inclock or negedge reset_n) begin
        if (!reset_n) drop_q <= '0;
        else if (push_req && !push && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
    end

    assign drop_cnt = drop_q;
`endif

    assign rx_data_align = align_q;
    assign rx_align_done = done_q;
    assign deq_rx        = deq_q;
    assign EN_deq_rx     = en_q;
    assign led_rx_state  = {1'b0, state_q};
endmodule

// File: tb/tb_lvds_rx_deframer.sv
// tb_lvds_rx_deframer: directed vectors for alignment, word assembly, FIFO overflow, lock loss and async reset.
module tb_lvds_rx_deframer;
    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        rx_locked = 1'b0;
    logic [7:0]  rx_out = 8'h00;
    logic        RDY_deq_rx = 1'b1;
    logic        rx_data_align, rx_align_done, EN_deq_rx;
    logic [31:0] deq_rx;
    logic [3:0]  led_rx_state;
`ifdef LVDS_RX_DROP_CNT_EN
    logic [7:0]  drop_cnt;
`endif
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] rx_q [$];

    lvds_rx_deframer dut (
        .rx_inclock   (clk),
        .reset_n      (reset_n),
        .rx_locked    (rx_locked),
        .rx_out       (rx_out),
        .rx_data_align(rx_data_align),
        .rx_align_done(rx_align_done),
        .deq_rx       (deq_rx),
        .EN_deq_rx    (EN_deq_rx),
        .RDY_deq_rx   (RDY_deq_rx),
        .led_rx_state (led_rx_state)
`ifdef LVDS_RX_DROP_CNT_EN
        ,
        .drop_cnt     (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (EN_deq_rx) rx_q.push_back(deq_rx);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input logic [7:0] b);
        rx_out = b;
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [31:0] w);
        tick(w[31:24]);
        tick(w[23:16]);
        tick(w[15:8]);
        tick(w[7:0]);
    endtask

    initial begin
        int base;
        #1 reset_n = 1'b0;
        #2;
        check("rst_state", 32'(led_rx_state), 32'd0);
        check("rst_align", 32'(rx_data_align), 32'd1);
        check("rst_done", 32'(rx_align_done), 32'd0);
        check("rst_en", 32'(EN_deq_rx), 32'd0);
        check("rst_deq", deq_rx, 32'h0);
`ifdef LVDS_RX_DROP_CNT_EN
        check("rst_drop", 32'(drop_cnt), 32'd0);
`endif
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n   = 1'b1;
        rx_locked = 1'b1;
        tick(8'h35);
        check("idle_to_hunt", 32'(led_rx_state), 32'd1);
        check("hunt_align0", 32'(rx_data_align), 32'd1);
        for (int i = 0; i < 5; i++) begin
            tick(8'h35);
            check("hunt_toggle", 32'(rx_data_align), (i % 2 == 0) ? 32'd0 : 32'd1);
        end
        tick(8'h6A);
        check("train_state", 32'(led_rx_state), 32'd2);
        check("train_align", 32'(rx_data_align), 32'd0);
        for (int i = 0; i < 7; i++) tick(8'h00);
        check("settle7_state", 32'(led_rx_state), 32'd2);
        check("settle7_done", 32'(rx_align_done), 32'd0);
        tick(8'h00);
        check("settle8_state", 32'(led_rx_state), 32'd3);
        check("settle8_done", 32'(rx_align_done), 32'd1);
        check("settle8_align", 32'(rx_data_align), 32'd0);
        tick(8'h00);
        check("mark_wait", 32'(led_rx_state), 32'd3);
        tick(8'h77);
        check("mark_hit", 32'(led_rx_state), 32'd4);
        send_word(32'h81223344);
        check("push_no_en", 32'(EN_deq_rx), 32'd0);
        check("b3_to_b0", 32'(led_rx_state), 32'd4);
        tick(8'h12);
        check("lat_en", 32'(EN_deq_rx), 32'd1);
        check("lat_deq", deq_rx, 32'h81223344);
        tick(8'h34);
        check("one_pulse", 32'(EN_deq_rx), 32'd0);
        check("deq_hold", deq_rx, 32'h81223344);
        tick(8'h56);
        tick(8'h78);
        RDY_deq_rx = 1'b0;
        for (int k = 1; k <= 6; k++) send_word(32'h80000000 | 32'(k));
        check("idle_fill_pulses", 32'(rx_q.size()), 32'd1);
        check("full_no_en", 32'(EN_deq_rx), 32'd0);
`ifdef LVDS_RX_DROP_CNT_EN
        check("drop_cnt", 32'(drop_cnt), 32'd2);
`endif
        RDY_deq_rx = 1'b1;
        tick(8'h00);
        check("drain_en", 32'(EN_deq_rx), 32'd1);
        check("drain_first", deq_rx, 32'h80000001);
        tick(8'h00);
        tick(8'h00);
        tick(8'h00);
        send_word(32'h0);
        check("drain_count", 32'(rx_q.size()), 32'd5);
        for (int k = 1; k <= 4; k++) check("drain_order", rx_q[k], 32'h80000000 | 32'(k));
        RDY_deq_rx = 1'b0;
        send_word(32'h80000007);
        tick(8'h85);
        tick(8'h11);
        check("in_b2", 32'(led_rx_state), 32'd6);
        rx_locked  = 1'b0;
        RDY_deq_rx = 1'b1;
        tick(8'h22);
        check("unlock_state", 32'(led_rx_state), 32'd0);
        check("unlock_done", 32'(rx_align_done), 32'd0);
        check("unlock_align", 32'(rx_data_align), 32'd1);
        check("unlock_drain_en", 32'(EN_deq_rx), 32'd1);
        check("unlock_drain", deq_rx, 32'h80000007);
        for (int i = 0; i < 3; i++) tick(8'h44);
        check("unlock_stay", 32'(led_rx_state), 32'd0);
        check("no_partial", 32'(rx_q.size()), 32'd6);
        rx_locked = 1'b1;
        tick(8'h00);
        check("relock_hunt", 32'(led_rx_state), 32'd1);
        tick(8'h6A);
        for (int i = 0; i < 8; i++) tick(8'h00);
        check("relock_mark", 32'(led_rx_state), 32'd3);
        tick(8'h77);
        RDY_deq_rx = 1'b0;
        send_word(32'h80000008);
        RDY_deq_rx = 1'b1;
        tick(8'h90);
        check("pre_rst_state", 32'(led_rx_state), 32'd5);
        check("pre_rst_en", 32'(EN_deq_rx), 32'd1);
        check("pre_rst_deq", deq_rx, 32'h80000008);
        #2 reset_n = 1'b0;
        #1;
        check("arst_state", 32'(led_rx_state), 32'd0);
        check("arst_align", 32'(rx_data_align), 32'd1);
        check("arst_done", 32'(rx_align_done), 32'd0);
        check("arst_en", 32'(EN_deq_rx), 32'd0);
        check("arst_deq", deq_rx, 32'h0);
`ifdef LVDS_RX_DROP_CNT_EN
        check("arst_drop", 32'(drop_cnt), 32'd0);
`endif
        base = rx_q.size();
        @(negedge clk);
        reset_n   = 1'b1;
        rx_locked = 1'b0;
        for (int i = 0; i < 3; i++) tick(8'h6A);
        check("post_rst_idle", 32'(led_rx_state), 32'd0);
        check("post_rst_empty", 32'(rx_q.size()), 32'(base));
        rx_locked = 1'b1;
        tick(8'h00);
        check("post_rst_hunt", 32'(led_rx_state), 32'd1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
